// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: load-use bubbles, EX redirects
// and data-memory waits, plus a stall-cycle counter and sticky memory-timeout flag.
module pipe_hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int LU_BUBBLES = 1,
  parameter int MEM_TMO    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_redirect,
  input  logic              mem_access,
  input  logic              dmem_ready,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              ifid_flush,
  output logic              idex_stall,
  output logic              idex_flush,
  output logic              exmem_stall,
  output logic              memwb_flush,
  output logic              mem_tmo_err,
  output logic [31:0]       stall_cnt,
  output logic [1:0]        dbgState    // 0 = RUN, 1 = LU_HOLD, 2 = MEM_WAIT
);

  localparam int TW = $clog2(MEM_TMO + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_HOLD  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t        stateQ;
  logic [TW-1:0] tmoCnt;
  logic [TW-1:0] tmoInc;
  logic          lu;
  logic          mw;
  logic          doMem;
  logic          doRedir;
  logic          doLu;

  assign lu = ex_mem_read && (ex_rd != '0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  assign mw = mem_access && !dmem_ready;
  assign tmoInc = tmoCnt + TW'(1);

  // One action per cycle; a pending memory wait always wins.
  always_comb begin
    doMem   = 1'b0;
    doRedir = 1'b0;
    doLu    = 1'b0;
    if (!rst) begin
      unique case (stateQ)
        RUN: begin
          doMem   = mw;
          doRedir = !mw && ex_redirect;
          doLu    = !mw && !ex_redirect && lu;
        end
        LU_HOLD: begin
          doMem = mw;
          doLu  = !mw;
        end
        MEM_WAIT: doMem = mw;
        default: ;
      endcase
    end
  end

  assign pc_stall    = doMem || doLu;
  assign ifid_stall  = doMem || doLu;
  assign ifid_flush  = doRedir;
  assign idex_stall  = doMem;
  assign idex_flush  = doRedir || doLu;
  assign exmem_stall = doMem;
  assign memwb_flush = doMem;
  assign dbgState    = stateQ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ      <= RUN;
      tmoCnt      <= '0;
      mem_tmo_err <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      if (pc_stall && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      unique case (stateQ)
        RUN: begin
          if (mw) begin
            stateQ <= MEM_WAIT;
            tmoCnt <= TW'(1);
          end else if (!ex_redirect && lu && (LU_BUBBLES == 2)) begin
            stateQ <= LU_HOLD;
          end
        end
        LU_HOLD: begin
          if (mw) begin
            stateQ <= MEM_WAIT;
            tmoCnt <= TW'(1);
          end else begin
            stateQ <= RUN;
          end
        end
        MEM_WAIT: begin
          if (!mw) begin
            stateQ <= RUN;
          end else begin
            tmoCnt <= tmoInc;
            // Give up on the access: the pipeline resumes with undefined MEM/WB data.
            if (tmoInc >= TW'(MEM_TMO)) begin
              mem_tmo_err <= 1'b1;
              stateQ      <= RUN;
            end
          end
        end
        default: stateQ <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (1 and 2 load-use bubbles, 4-cycle
// memory timeout) driven with directed scenarios and random traffic.
module tb_pipe_hazard_ctrl;

  // Control vector bit order: pc_stall, ifid_stall, ifid_flush, idex_stall,
  // idex_flush, exmem_stall, memwb_flush.
  localparam logic [6:0] ZERO = 7'b0000000;
  localparam logic [6:0] LUO  = 7'b1100100;
  localparam logic [6:0] RDO  = 7'b0010100;
  localparam logic [6:0] MWO  = 7'b1101011;
  localparam int TMO = 4;

  // clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, ex_mem_read = 0, ex_redirect = 0;
  logic mem_access = 0, dmem_ready = 0;

  wire [6:0]  ctlA, ctlB;
  wire [31:0] scA, scB;
  wire        errA, errB;
  wire [1:0]  dbgA, dbgB;

  int nChecks = 0;
  int nFails  = 0;

  pipe_hazard_ctrl #(.REG_AW(5), .LU_BUBBLES(1), .MEM_TMO(TMO)) dutA (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_stall(ctlA[6]), .ifid_stall(ctlA[5]), .ifid_flush(ctlA[4]),
    .idex_stall(ctlA[3]), .idex_flush(ctlA[2]), .exmem_stall(ctlA[1]),
    .memwb_flush(ctlA[0]), .mem_tmo_err(errA), .stall_cnt(scA), .dbgState(dbgA)
  );

  pipe_hazard_ctrl #(.REG_AW(5), .LU_BUBBLES(2), .MEM_TMO(TMO)) dutB (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_stall(ctlB[6]), .ifid_stall(ctlB[5]), .ifid_flush(ctlB[4]),
    .idex_stall(ctlB[3]), .idex_flush(ctlB[2]), .exmem_stall(ctlB[1]),
    .memwb_flush(ctlB[0]), .mem_tmo_err(errB), .stall_cnt(scB), .dbgState(dbgB)
  );

  function automatic logic [6:0] ctlOf(int k);
    return (k == 0) ? ctlA : ctlB;
  endfunction
  function automatic logic [31:0] cntOf(int k);
    return (k == 0) ? scA : scB;
  endfunction
  function automatic logic errOf(int k);
    return (k == 0) ? errA : errB;
  endfunction

  // Reference model: bubbles still owed, length of the current memory wait,
  // sticky error and a plain stall tally, per instance.
  int     bub[2] = '{1, 2};
  int     holdLeft[2];
  int     waitN[2];
  bit     mWait[2];
  bit     mErr[2];
  longint mStalls[2];

  function automatic bit luNow();
    return ex_mem_read && (ex_rd != 0) &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction

  function automatic bit mwNow();
    return mem_access && !dmem_ready;
  endfunction

  function automatic logic [6:0] modelCtl(int k);
    if (rst) return ZERO;
    if (mWait[k]) return mwNow() ? MWO : ZERO;
    if (mwNow()) return MWO;
    if (holdLeft[k] > 0) return LUO;
    if (ex_redirect) return RDO;
    if (luNow()) return LUO;
    return ZERO;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      holdLeft[k] = 0; waitN[k] = 0; mWait[k] = 0; mErr[k] = 0; mStalls[k] = 0;
    end
  endtask

  task automatic modelStep();
    logic [6:0] c;
    if (rst) begin
      modelReset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      c = modelCtl(k);
      if (c[6] && mStalls[k] < 64'hFFFF_FFFF) mStalls[k]++;
      if (mWait[k]) begin
        if (!mwNow()) mWait[k] = 0;
        else begin
          waitN[k]++;
          if (waitN[k] >= TMO) begin mErr[k] = 1; mWait[k] = 0; end
        end
      end else if (mwNow()) begin
        mWait[k] = 1; waitN[k] = 1; holdLeft[k] = 0;
      end else if (holdLeft[k] > 0) holdLeft[k]--;
      else if (!ex_redirect && luNow()) holdLeft[k] = bub[k] - 1;
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic clearInputs();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_mem_read = 0; ex_redirect = 0; mem_access = 0; dmem_ready = 0;
  endtask

  task automatic applyReset();
    clearInputs();
    rst = 1;
    modelReset();
    tick();
    tick();
    rst = 0;
  endtask

  task automatic setHazard();
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
  endtask

  task automatic test_reset();
    rst = 1;
    setHazard();
    mem_access = 1; dmem_ready = 0; ex_redirect = 1;
    modelReset();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      nChecks++;
      if (ctlOf(k) !== ZERO) begin nFails++; $display("FAIL reset_ctl[%0d] got %b want %b", k, ctlOf(k), ZERO); end
      nChecks++;
      if (cntOf(k) !== 32'd0 || errOf(k) !== 1'b0) begin
        nFails++; $display("FAIL reset_regs[%0d] cnt=%0d err=%b want 0/0", k, cntOf(k), errOf(k));
      end
    end
    nChecks++;
    if (dbgA !== 2'd0 || dbgB !== 2'd0) begin nFails++; $display("FAIL reset_state got %0d/%0d want 0/0", dbgA, dbgB); end
    tick();
    rst = 0;
    clearInputs();
  endtask

  task automatic test_load_use();
    logic [6:0] exp[2];
    applyReset();
    setHazard();
    for (int c = 0; c < 3; c++) begin
      if (c == 1) clearInputs();
      exp[0] = (c == 0) ? LUO : ZERO;
      exp[1] = (c < 2) ? LUO : ZERO;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        nChecks++;
        if (ctlOf(k) !== exp[k]) begin nFails++; $display("FAIL load_use_ctl[%0d] cyc%0d got %b want %b", k, c, ctlOf(k), exp[k]); end
      end
      tick();
    end
    nChecks++;
    if (scA !== 32'd1) begin nFails++; $display("FAIL load_use_cnt1 got %0d want 1", scA); end
    nChecks++;
    if (scB !== 32'd2) begin nFails++; $display("FAIL load_use_cnt2 got %0d want 2", scB); end
  endtask

  task automatic test_no_hazard();
    applyReset();
    for (int c = 0; c < 3; c++) begin
      clearInputs();
      ex_mem_read = 1;
      case (c)
        0: begin ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1; end
        1: begin ex_rd = 5; id_rs1 = 5; id_use_rs1 = 0; id_rs2 = 3; id_use_rs2 = 1; end
        default: begin ex_rd = 7; id_rs1 = 6; id_use_rs1 = 1; id_rs2 = 7; id_use_rs2 = 0; end
      endcase
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        nChecks++;
        if (ctlOf(k) !== ZERO) begin nFails++; $display("FAIL no_hazard_ctl[%0d] case%0d got %b want %b", k, c, ctlOf(k), ZERO); end
      end
      tick();
    end
    nChecks++;
    if (scA !== 32'd0 || scB !== 32'd0) begin nFails++; $display("FAIL no_hazard_cnt got %0d/%0d want 0/0", scA, scB); end
  endtask

  task automatic test_redirect();
    applyReset();
    setHazard();
    ex_redirect = 1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      nChecks++;
      if (ctlOf(k) !== RDO) begin nFails++; $display("FAIL redirect_ctl[%0d] got %b want %b", k, ctlOf(k), RDO); end
    end
    tick();
    clearInputs();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      nChecks++;
      if (ctlOf(k) !== ZERO || cntOf(k) !== 32'd0) begin
        nFails++; $display("FAIL redirect_after[%0d] ctl=%b cnt=%0d want %b/0", k, ctlOf(k), cntOf(k), ZERO);
      end
    end
    tick();
  endtask

  task automatic test_mem_wait();
    logic [6:0] exp;
    applyReset();
    mem_access = 1; dmem_ready = 0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 2) ex_redirect = 1;
      if (c == 4) dmem_ready = 1;
      if (c == 5) begin mem_access = 0; dmem_ready = 0; end
      exp = (c <= 3) ? MWO : (c == 4) ? ZERO : RDO;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        nChecks++;
        if (ctlOf(k) !== exp) begin nFails++; $display("FAIL mem_wait_ctl[%0d] cyc%0d got %b want %b", k, c, ctlOf(k), exp); end
      end
      tick();
    end
    ex_redirect = 0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      nChecks++;
      if (cntOf(k) !== 32'd3 || errOf(k) !== 1'b0) begin
        nFails++; $display("FAIL mem_wait_cnt[%0d] cnt=%0d err=%b want 3/0", k, cntOf(k), errOf(k));
      end
    end
    tick();
  endtask

  task automatic test_timeout();
    applyReset();
    mem_access = 1; dmem_ready = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        nChecks++;
        if (ctlOf(k) !== MWO || errOf(k) !== 1'b0) begin
          nFails++; $display("FAIL timeout_wait[%0d] cyc%0d ctl=%b err=%b want %b/0", k, c, ctlOf(k), errOf(k), MWO);
        end
      end
      tick();
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      nChecks++;
      if (errOf(k) !== 1'b1) begin nFails++; $display("FAIL timeout_err[%0d] got %b want 1", k, errOf(k)); end
    end
    nChecks++;
    if (dbgA !== 2'd0 || dbgB !== 2'd0) begin nFails++; $display("FAIL timeout_state got %0d/%0d want 0/0", dbgA, dbgB); end
    tick();
    mem_access = 0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      nChecks++;
      if (ctlOf(k) !== ZERO || errOf(k) !== 1'b1 || cntOf(k) !== 32'd5) begin
        nFails++; $display("FAIL timeout_sticky[%0d] ctl=%b err=%b cnt=%0d want %b/1/5", k, ctlOf(k), errOf(k), cntOf(k), ZERO);
      end
    end
    tick();
    mem_access = 1;
    tick();
    @(negedge clk);
    rst = 1;
    modelReset();
    #1;
    for (int k = 0; k < 2; k++) begin
      nChecks++;
      if (ctlOf(k) !== ZERO || errOf(k) !== 1'b0 || cntOf(k) !== 32'd0) begin
        nFails++; $display("FAIL timeout_rst[%0d] ctl=%b err=%b cnt=%0d want %b/0/0", k, ctlOf(k), errOf(k), cntOf(k), ZERO);
      end
    end
    mem_access = 0;
    tick();
    rst = 0;
  endtask

  task automatic test_random();
    bit slow;
    applyReset();
    for (int i = 0; i < 400; i++) begin
      slow = ((i / 40) % 2) == 1;
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      ex_rd  = 5'($urandom_range(0, 3));
      id_use_rs1  = 1'($urandom_range(0, 1));
      id_use_rs2  = 1'($urandom_range(0, 1));
      ex_mem_read = 1'($urandom_range(0, 1));
      ex_redirect = ($urandom_range(0, 5) == 0);
      mem_access  = slow ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      dmem_ready  = slow ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 99) == 0) begin
        rst = 1;
        modelReset();
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        nChecks++;
        if (ctlOf(k) !== modelCtl(k)) begin nFails++; $display("FAIL random_ctl[%0d] i=%0d got %b want %b", k, i, ctlOf(k), modelCtl(k)); end
        nChecks++;
        if (cntOf(k) !== 32'(mStalls[k]) || errOf(k) !== mErr[k]) begin
          nFails++; $display("FAIL random_regs[%0d] i=%0d cnt=%0d err=%b want %0d/%b", k, i, cntOf(k), errOf(k), mStalls[k], mErr[k]);
        end
      end
      tick();
      rst = 0;
    end
    clearInputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_redirect();
    test_mem_wait();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
